// File: rtl/fibo_checker_pkg.sv
// rtl/fibo_checker_pkg.sv - shared operand width and checker state encodings
package fibo_checker_pkg;

  localparam int OPERAND_BUS = 6;

  typedef enum logic [1:0] {
    FCHK_IDLE = 2'd0,
    FCHK_CHK  = 2'd1,
    FCHK_DONE = 2'd2,
    FCHK_FAIL = 2'd3
  } fchk_state_t;

endpackage

// File: rtl/fibo_ref_gen.sv
// rtl/fibo_ref_gen.sv - reference Fibonacci register pair with seed load and step
module fibo_ref_gen
  import fibo_checker_pkg::*;
#(
  parameter int WIDTH = OPERAND_BUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_seed_a,
  input  logic [WIDTH-1:0] i_seed_b,
  output logic [WIDTH-1:0] o_expect
);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_expect;
  logic             r_first;
  logic [WIDTH-1:0] w_sum;

  // Carry out of the sum is dropped on purpose: the sequence wraps mod 2^WIDTH.
  assign w_sum = r_prev + r_cur;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev   <= '0;
      r_cur    <= '0;
      r_expect <= '0;
      r_first  <= 1'b0;
    end else if (i_load) begin
      r_prev   <= i_seed_a;
      r_cur    <= i_seed_b;
      r_expect <= i_seed_a;
      r_first  <= 1'b1;
    end else if (i_step) begin
      r_first <= 1'b0;
      if (r_first) begin
        // term 0 matched: next expected is the second seed, pair stays put
        r_expect <= r_cur;
      end else begin
        r_prev   <= r_cur;
        r_cur    <= w_sum;
        r_expect <= w_sum;
      end
    end
  end

  assign o_expect = r_expect;

endmodule

// File: rtl/fibo_checker.sv
// rtl/fibo_checker.sv - checks a received Fibonacci term stream against a regenerated reference
module fibo_checker
  import fibo_checker_pkg::*;
#(
  parameter int WIDTH     = OPERAND_BUS,
  parameter int NUM_TERMS = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] expect_term,
  output logic [CNT_W-1:0] idx,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_idx,
  output logic [WIDTH-1:0] err_data
);

  fchk_state_t      r_state;
  fchk_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_err_idx;
  logic [WIDTH-1:0] r_err_data;
  logic [WIDTH-1:0] w_expect;
  logic             w_sample;
  logic             w_hit;
  logic             w_last;

  // start always wins, so a sample arriving alongside it is dropped
  assign w_sample = (r_state == FCHK_CHK) && in_valid && !start;
  assign w_hit    = w_sample && (C == w_expect);
  assign w_last   = (r_idx == CNT_W'(NUM_TERMS - 1));

  fibo_ref_gen #(.WIDTH(WIDTH)) u_ref_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (start),
    .i_step   (w_hit),
    .i_seed_a (A),
    .i_seed_b (B),
    .o_expect (w_expect)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= FCHK_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = FCHK_CHK;
    end else if (w_sample) begin
      if (!w_hit)      w_state_nxt = FCHK_FAIL;
      else if (w_last) w_state_nxt = FCHK_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || start) begin
      r_idx       <= '0;
      r_match_cnt <= '0;
      r_err_idx   <= '0;
      r_err_data  <= '0;
    end else if (w_hit) begin
      r_idx       <= r_idx + 1'b1;
      r_match_cnt <= r_match_cnt + 1'b1;
    end else if (w_sample) begin
      r_err_idx  <= r_idx;
      r_err_data <= C;
    end
  end

  assign expect_term = w_expect;
  assign idx         = r_idx;
  assign match_cnt   = r_match_cnt;
  assign busy        = (r_state == FCHK_CHK);
  assign done        = (r_state == FCHK_DONE);
  assign err         = (r_state == FCHK_FAIL);
  assign err_idx     = r_err_idx;
  assign err_data    = r_err_data;

endmodule

// File: tb/tb_fibo_checker.sv
// tb/tb_fibo_checker.sv - directed self-checking bench for fibo_checker
module tb_fibo_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] A, B, C;
  logic       in_valid;
  logic [5:0] expect_term;
  logic [7:0] idx, match_cnt, err_idx;
  logic       busy, done, err;
  logic [5:0] err_data;

  int total = 0;
  int bad   = 0;
  int seq[16];
  logic busy_ok;

  fibo_checker #(.WIDTH(6), .NUM_TERMS(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .in_valid    (in_valid),
    .C           (C),
    .expect_term (expect_term),
    .idx         (idx),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_idx     (err_idx),
    .err_data    (err_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] a, input logic [5:0] b);
    A = a; B = b; start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [5:0] v);
    C = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic feed_seq(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      feed(6'(seq[i]));
      for (int g = 0; g < gap; g++) begin
        tick();
        if (i != n - 1 && busy !== 1'b1) busy_ok = 1'b0;
      end
      if (gap > 0 && i != n - 1 && busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; A = 6'd7; B = 6'd9; C = 6'd7;
    tick(); tick();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_expect", expect_term, 0);
    chk("rst_idx", idx, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_flags", {busy, done, err}, 0);
    chk("rst_err", {err_idx, 2'b00, err_data}, 0);
    feed(6'd0);
    chk("idle_ignore", {busy, idx}, 0);

    // clean pass, wraps at 89 -> 25
    seq = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16, 41, 57, 34, 27, 61};
    do_start(6'd1, 6'd2);
    chk("start_expect", expect_term, 1);
    chk("start_busy", busy, 1);
    feed_seq(16, 0);
    chk("clean_done", done, 1);
    chk("clean_match", match_cnt, 16);
    chk("clean_idx", idx, 16);
    chk("clean_err_busy", {err, busy}, 0);
    chk("clean_next_expect", expect_term, 24);
    feed(6'd24);
    chk("done_hold", {done, match_cnt}, {1'b1, 8'd16});

    // mismatch at term 3
    do_start(6'd1, 6'd2);
    feed(6'd1); feed(6'd2); feed(6'd3);
    chk("pre_err_expect", expect_term, 5);
    feed(6'd6);
    chk("mm_err", {err, busy, done}, 3'b100);
    chk("mm_err_idx", err_idx, 3);
    chk("mm_err_data", err_data, 6);
    chk("mm_match", match_cnt, 3);
    feed(6'd5); feed(6'd9);
    chk("mm_freeze", {err, idx, match_cnt, err_idx, err_data, expect_term},
        {1'b1, 8'd3, 8'd3, 8'd3, 6'd6, 6'd5});

    // recovery from FAIL
    do_start(6'd3, 6'd3);
    chk("rec_err", err, 0);
    chk("rec_expect", expect_term, 3);
    feed(6'd3); feed(6'd3); feed(6'd6); feed(6'd9); feed(6'd15);
    chk("rec_match", match_cnt, 5);
    chk("rec_state", {busy, idx, expect_term}, {1'b1, 8'd5, 6'd24});

    // gaps between terms
    seq = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16, 41, 57, 34, 27, 61};
    busy_ok = 1'b1;
    do_start(6'd1, 6'd2);
    feed_seq(16, 3);
    chk("gap_busy", busy_ok, 1);
    chk("gap_done", {done, err, match_cnt}, {1'b1, 1'b0, 8'd16});

    // restart mid-stream with a simultaneous sample
    do_start(6'd1, 6'd2);
    feed_seq(5, 0);
    chk("pre_restart_idx", idx, 5);
    A = 6'd0; B = 6'd1; C = 6'd8; start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("restart_state", {busy, idx, match_cnt, expect_term}, {1'b1, 8'd0, 8'd0, 6'd0});
    seq = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16, 41, 57, 34};
    feed_seq(16, 0);
    chk("restart_done", {done, err, match_cnt}, {1'b1, 1'b0, 8'd16});

    // reset mid-check aborts without flags
    do_start(6'd1, 6'd2);
    feed(6'd1); feed(6'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst", {busy, done, err, idx, match_cnt, expect_term}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
